// File: rtl/program_loader_pkg.sv
// Shared command codes, FSM state and target encodings for the program loader.
package loader_pkg;

  localparam logic [7:0] CMD_LOAD_IMEM = 8'h00;
  localparam logic [7:0] CMD_LOAD_DMEM = 8'h01;
  localparam logic [7:0] CMD_RUN       = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_LO = 3'd1,
    ST_CNT_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_RUN    = 3'd5,
    ST_ERROR  = 3'd6
  } state_e;

  typedef enum logic {
    TGT_IMEM = 1'b0,
    TGT_DMEM = 1'b1
  } target_e;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input, memory write ports and CPU control of the program loader.
// The loader side uses the master modport, the environment the slave modport.
interface program_loader_if #(
  parameter int IMEM_AW = 10,
  parameter int DMEM_AW = 10
);
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               rx_ready;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_wdata;
  logic               dmem_we;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [31:0]        dmem_wdata;
  logic               cpu_reset;
  logic               done;
  logic               error;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata,
    output dmem_we, dmem_addr, dmem_wdata, cpu_reset, done, error
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata,
    input  dmem_we, dmem_addr, dmem_wdata, cpu_reset, done, error
  );
endinterface

// File: rtl/program_loader_packer.sv
// Little-endian byte-to-word packer: the first byte of a word lands in [7:0].
// word_valid/word_out are combinational and describe the word completed by
// the byte being accepted this cycle.
module byte_to_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word_out
);
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] sr_q, sr_d;

  // Next byte count and shift contents; clear discards any partial word.
  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (clear) begin
      cnt_d = 2'd0;
      sr_d  = 32'd0;
    end else if (byte_valid) begin
      cnt_d = cnt_q + 2'd1;
      sr_d  = {byte_in, sr_q[31:8]};
    end else begin
      cnt_d = cnt_q;
      sr_d  = sr_q;
    end
    word_valid = byte_valid && !clear && (cnt_q == 2'd3);
    word_out   = {byte_in, sr_q[31:8]};
  end

  // Byte counter and shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 2'd0;
      sr_q  <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end
endmodule

// File: rtl/program_loader.sv
// Program/data loader: parses LOAD/RUN frames from a byte stream, writes
// little-endian words into IMEM/DMEM and holds the CPU in reset until RUN.
module program_loader
  import loader_pkg::*;
#(
  parameter int IMEM_AW = 10,
  parameter int DMEM_AW = 10
) (
  input logic              clk,
  input logic              reset,
  program_loader_if.master bus
);
  localparam logic [16:0] IMEM_LIMIT = 17'd1 << IMEM_AW;
  localparam logic [16:0] DMEM_LIMIT = 17'd1 << DMEM_AW;

  state_e             state_q, state_d;
  target_e            target_q, target_d;
  logic [15:0]        count_q, count_d;
  logic [16:0]        index_q, index_d;
  logic [7:0]         csum_q, csum_d;
  logic               rx_ready_q, rx_ready_d;
  logic               imem_we_q, imem_we_d;
  logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]        imem_wdata_q, imem_wdata_d;
  logic               dmem_we_q, dmem_we_d;
  logic [DMEM_AW-1:0] dmem_addr_q, dmem_addr_d;
  logic [31:0]        dmem_wdata_q, dmem_wdata_d;
  logic               cpu_reset_q, cpu_reset_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  logic        accept_s;
  logic        word_valid_s;
  logic [31:0] word_s;
  logic [15:0] n_s;
  logic [16:0] limit_s;

  assign accept_s = bus.rx_valid && rx_ready_q;

  // The packer only runs inside a segment's data phase.
  byte_to_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (state_q != ST_DATA),
    .byte_valid (accept_s),
    .byte_in    (bus.rx_data),
    .word_valid (word_valid_s),
    .word_out   (word_s)
  );

  // Frame parser: next state, segment bookkeeping and registered outputs.
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    count_d      = count_q;
    index_d      = index_q;
    csum_d       = csum_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    dmem_we_d    = 1'b0;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    n_s          = {bus.rx_data, count_q[7:0]};
    limit_s      = (target_q == TGT_DMEM) ? DMEM_LIMIT : IMEM_LIMIT;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          index_d = 17'd0;
          csum_d  = 8'd0;
          case (bus.rx_data)
            CMD_LOAD_IMEM: begin target_d = TGT_IMEM; state_d = ST_CNT_LO; end
            CMD_LOAD_DMEM: begin target_d = TGT_DMEM; state_d = ST_CNT_LO; end
            CMD_RUN:       state_d = ST_RUN;
            default:       state_d = ST_ERROR;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CNT_LO: begin
        if (accept_s) begin
          count_d = {8'd0, bus.rx_data};
          state_d = ST_CNT_HI;
        end else begin
          state_d = ST_CNT_LO;
        end
      end
      ST_CNT_HI: begin
        if (accept_s) begin
          count_d = n_s;
          if ({1'b0, n_s} > limit_s) begin
            state_d = ST_ERROR;
          end else if (n_s == 16'd0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_CNT_HI;
        end
      end
      ST_DATA: begin
        if (accept_s) begin
          csum_d = csum_q ^ bus.rx_data;
          if (word_valid_s) begin
            if (target_q == TGT_DMEM) begin
              dmem_we_d    = 1'b1;
              dmem_addr_d  = index_q[DMEM_AW-1:0];
              dmem_wdata_d = word_s;
            end else begin
              imem_we_d    = 1'b1;
              imem_addr_d  = index_q[IMEM_AW-1:0];
              imem_wdata_d = word_s;
            end
            index_d = index_q + 17'd1;
            if ((index_q + 17'd1) == {1'b0, count_q}) begin
              state_d = ST_CSUM;
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (accept_s) begin
          state_d = (bus.rx_data == csum_q) ? ST_IDLE : ST_ERROR;
        end else begin
          state_d = ST_CSUM;
        end
      end
      ST_RUN:   state_d = ST_RUN;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase

    rx_ready_d  = (state_d != ST_RUN) && (state_d != ST_ERROR);
    cpu_reset_d = (state_d != ST_RUN);
    done_d      = (state_d == ST_RUN);
    error_d     = (state_d == ST_ERROR);
  end

  // State and output registers; rx_ready rises on the first edge after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      target_q     <= TGT_IMEM;
      count_q      <= 16'd0;
      index_q      <= 17'd0;
      csum_q       <= 8'd0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= 32'd0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      count_q      <= count_d;
      index_q      <= index_d;
      csum_q       <= csum_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.rx_ready   = rx_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign bus.dmem_we    = dmem_we_q;
  assign bus.dmem_addr  = dmem_addr_q;
  assign bus.dmem_wdata = dmem_wdata_q;
  assign bus.cpu_reset  = cpu_reset_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frames with hand-computed expectations,
// write strobes captured on the falling edge into small memory images.
module tb_program_loader;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   gap_max;
  int   imem_cnt;
  int   dmem_cnt;
  logic [31:0] imem_m [0:1023];
  logic [31:0] dmem_m [0:1023];
  logic [7:0]  seq [$];

  program_loader_if #(.IMEM_AW(10), .DMEM_AW(10)) ifc ();

  program_loader #(.IMEM_AW(10), .DMEM_AW(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every write strobe once (strobe is high for one full cycle).
  always @(negedge clk) begin
    if (ifc.imem_we) begin
      imem_m[ifc.imem_addr] = ifc.imem_wdata;
      imem_cnt = imem_cnt + 1;
    end
    if (ifc.dmem_we) begin
      dmem_m[ifc.dmem_addr] = ifc.dmem_wdata;
      dmem_cnt = dmem_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    imem_cnt = 0;
    dmem_cnt = 0;
    for (int i = 0; i < 1024; i++) begin
      imem_m[i] = 32'd0;
      dmem_m[i] = 32'd0;
    end
  endtask

  // Assert reset, check reset values, release and check rx_ready rising.
  task automatic do_reset();
    ifc.rx_valid = 1'b0;
    ifc.rx_data  = 8'h00;
    reset = 1'b1;
    #1;
    check_eq("rst_cpu_reset", {31'd0, ifc.cpu_reset}, 32'd1);
    check_eq("rst_we", {30'd0, ifc.imem_we, ifc.dmem_we}, 32'd0);
    repeat (2) @(negedge clk);
    check_eq("rst_outs", {ifc.rx_ready, ifc.done, ifc.error, 9'd0, 10'(ifc.imem_addr), 10'(ifc.dmem_addr)}, 32'd0);
    check_eq("rst_wdata", ifc.imem_wdata | ifc.dmem_wdata, 32'd0);
    clear_model();
    reset = 1'b0;
    #1;
    check_eq("rdy_after_release", {31'd0, ifc.rx_ready}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("rdy_one_edge", {31'd0, ifc.rx_ready}, 32'd1);
  endtask

  // Offer one byte and wait (bounded) until it is accepted on a rising edge.
  task automatic send_byte(input logic [7:0] b);
    int  n;
    bit  acc;
    if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(posedge clk);
    #1;
    ifc.rx_data  = b;
    ifc.rx_valid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 8) begin
      if (ifc.rx_ready) acc = 1'b1;
      @(posedge clk);
      #1;
      n = n + 1;
    end
    ifc.rx_valid = 1'b0;
    if (!acc) check_eq("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_seq();
    foreach (seq[i]) send_byte(seq[i]);
  endtask

  // Drive bytes at a loader that should be ignoring them.
  task automatic drive_ignored();
    ifc.rx_data  = 8'h00;
    ifc.rx_valid = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    ifc.rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    gap_max = 0;
    reset   = 1'b1;
    ifc.rx_valid = 1'b0;
    ifc.rx_data  = 8'h00;
    clear_model();

    // Two-word IMEM program followed by RUN.
    do_reset();
    check_eq("idle_done", {31'd0, ifc.done}, 32'd0);
    seq = '{8'h00, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    send_seq();
    check_eq("we_after_4th", {31'd0, ifc.imem_we}, 32'd1);
    check_eq("wdata_after_4th", ifc.imem_wdata, 32'h0000_0013);
    check_eq("addr_after_4th", 32'(ifc.imem_addr), 32'd0);
    @(posedge clk); #1;
    check_eq("we_one_cycle", {31'd0, ifc.imem_we}, 32'd0);
    seq = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    send_seq();
    check_eq("pre_run_cpu_reset", {31'd0, ifc.cpu_reset}, 32'd1);
    send_byte(8'h02);
    check_eq("run_cpu_reset", {31'd0, ifc.cpu_reset}, 32'd0);
    check_eq("run_done", {31'd0, ifc.done}, 32'd1);
    check_eq("run_rdy", {31'd0, ifc.rx_ready}, 32'd0);
    check_eq("prog_imem_cnt", 32'(imem_cnt), 32'd2);
    check_eq("prog_imem0", imem_m[0], 32'h0000_0013);
    check_eq("prog_imem1", imem_m[1], 32'h0010_0093);
    check_eq("prog_dmem_cnt", 32'(dmem_cnt), 32'd0);

    // Empty DMEM segment, then one DMEM word (checksum EF^BE^AD^DE = 22).
    do_reset();
    seq = '{8'h01, 8'h00, 8'h00, 8'h00};
    send_seq();
    @(posedge clk); #1;
    check_eq("empty_seg_writes", 32'(dmem_cnt + imem_cnt), 32'd0);
    seq = '{8'h01, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    send_seq();
    check_eq("dmem_cnt", 32'(dmem_cnt), 32'd1);
    check_eq("dmem0", dmem_m[0], 32'hDEAD_BEEF);
    check_eq("dmem_no_imem", 32'(imem_cnt), 32'd0);
    check_eq("dmem_error", {31'd0, ifc.error}, 32'd0);
    check_eq("dmem_rdy", {31'd0, ifc.rx_ready}, 32'd1);
    send_byte(8'h02);
    check_eq("dmem_then_run", {31'd0, ifc.done}, 32'd1);

    // Checksum mismatch: word stays written, loader locks in ERROR.
    do_reset();
    seq = '{8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h5A};
    send_seq();
    check_eq("csum_err", {31'd0, ifc.error}, 32'd1);
    check_eq("csum_err_rdy", {31'd0, ifc.rx_ready}, 32'd0);
    check_eq("csum_err_cpu", {31'd0, ifc.cpu_reset}, 32'd1);
    check_eq("csum_err_imem0", imem_m[0], 32'hDDCC_BBAA);
    drive_ignored();
    check_eq("csum_err_sticky", {ifc.error, ifc.done, ifc.rx_ready}, 32'd4);
    check_eq("csum_err_cnt", 32'(imem_cnt), 32'd1);

    // Unknown command.
    do_reset();
    send_byte(8'h07);
    check_eq("bad_cmd_err", {31'd0, ifc.error}, 32'd1);
    check_eq("bad_cmd_rdy", {31'd0, ifc.rx_ready}, 32'd0);

    // N = 1025 exceeds IMEM depth.
    do_reset();
    seq = '{8'h00, 8'h01, 8'h04};
    send_seq();
    check_eq("n1025_err", {31'd0, ifc.error}, 32'd1);
    drive_ignored();
    check_eq("n1025_writes", 32'(imem_cnt + dmem_cnt), 32'd0);

    // N = 1024 is legal.
    do_reset();
    seq = '{8'h01, 8'h00, 8'h04};
    send_seq();
    check_eq("n1024_ok", {ifc.error, ifc.rx_ready}, 32'd1);

    // Reset after two data bytes, then a clean segment (csum 44^33^22^11=44).
    for (int pass = 0; pass < 2; pass++) begin
      gap_max = (pass == 0) ? 0 : 3;
      do_reset();
      seq = '{8'h00, 8'h01, 8'h00, 8'h11, 8'h22};
      send_seq();
      reset = 1'b1;
      #1;
      check_eq("abort_cpu_reset", {31'd0, ifc.cpu_reset}, 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check_eq("abort_no_strobe", 32'(imem_cnt), 32'd0);
      do_reset();
      seq = '{8'h00, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h44};
      send_seq();
      check_eq("replay_cnt", 32'(imem_cnt), 32'd1);
      check_eq("replay_imem0", imem_m[0], 32'h1122_3344);
      check_eq("replay_err", {31'd0, ifc.error}, 32'd0);
    end
    gap_max = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
